// File: rtl/ps2_pkg.sv
// ps2_pkg: shared PS/2 definitions for the host command sequencer and the scancode path.
package ps2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INHIBIT,
        ST_REQ,
        ST_SEND,
        ST_LACK,
        ST_RSP
    } ps2_state_e;

    localparam logic [7:0] PS2_ACK        = 8'hFA;
    localparam logic [7:0] PS2_RESEND     = 8'hFE;
    localparam logic [7:0] PS2_BAT_OK     = 8'hAA;
    localparam logic [7:0] PS2_CMD_RESET  = 8'hFF;
    localparam logic [7:0] PS2_CMD_LEDS   = 8'hED;
    localparam logic [7:0] PS2_CMD_ENABLE = 8'hF4;

    localparam int FRAME_LEN = 11;

    // Parity bit that makes the 9-bit data+parity group contain an odd number of ones.
    function automatic logic odd_parity(input logic [7:0] b);
        return ~^b;
    endfunction

endpackage

// File: rtl/ps2_host_ctl_if.sv
// ps2_host_ctl_if: command/response handshake between an upstream requester and ps2_host_ctl.
interface ps2_host_ctl_if;
    logic [7:0] cmd_data;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] rsp_data;
    logic       rsp_valid;
    logic       err;
    logic       busy;
    logic       rx_inhibit;

    modport master (
        output cmd_data, cmd_valid,
        input  cmd_ready, rsp_data, rsp_valid, err, busy, rx_inhibit
    );

    modport slave (
        input  cmd_data, cmd_valid,
        output cmd_ready, rsp_data, rsp_valid, err, busy, rx_inhibit
    );
endinterface

// File: rtl/ps2_line_sync.sv
// ps2_line_sync: two-flop synchronisers for the raw PS/2 lines plus a clock falling-edge strobe.
// Flops reset to 1 (idle line level) so releasing clr never fakes an edge.
module ps2_line_sync (
    input  logic clk,
    input  logic clr,
    input  logic ps2_clk_i,
    input  logic ps2_data_i,
    output logic data_sync_o,
    output logic clk_fall_o
);
    logic [1:0] clk_meta_q;
    logic [1:0] data_meta_q;
    logic       clk_prev_q;

    // NOTE: non-blocking so each stage captures its neighbour's pre-edge value.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            clk_meta_q  <= 2'b11;
            data_meta_q <= 2'b11;
            clk_prev_q  <= 1'b1;
        end else begin
            clk_meta_q  <= {clk_meta_q[0], ps2_clk_i};
            data_meta_q <= {data_meta_q[0], ps2_data_i};
            clk_prev_q  <= clk_meta_q[1];
        end
    end

    assign data_sync_o = data_meta_q[1];
    assign clk_fall_o  = clk_prev_q & ~clk_meta_q[1];
endmodule

// File: rtl/ps2_host_ctl.sv
// ps2_host_ctl: host-to-device PS/2 command sequencer with FE resend retries and edge-gap timeout.
// Line enables are decoded from the state register so clr releases the bus immediately.
module ps2_host_ctl #(
    parameter int INHIBIT_CYCLES = 2500,
    parameter int TIMEOUT_CYCLES = 500000,
    parameter int MAX_RETRIES    = 2
) (
    input  logic           clk,
    input  logic           clr,
    ps2_host_ctl_if.slave  bus,
    input  logic           ps2_clk_in,
    input  logic           ps2_data_in,
    output logic           ps2_clk_oe,
    output logic           ps2_data_oe
);
    import ps2_pkg::*;

    localparam int TMR_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int TW      = $clog2(TMR_MAX + 1);
    localparam int RW      = (MAX_RETRIES < 1) ? 1 : $clog2(MAX_RETRIES + 1);

    ps2_state_e           state_q, state_d;
    logic [7:0]           cmd_q, cmd_d;
    logic [RW-1:0]        retry_q, retry_d;
    logic [TW-1:0]        tmr_q, tmr_d;
    logic [3:0]           bit_q, bit_d;
    logic [FRAME_LEN-2:0] shift_q, shift_d;
    logic                 data_oe_q, data_oe_d;
    logic [7:0]           rsp_data_q, rsp_data_d;

    logic                 data_sync, clk_fall;
    logic [FRAME_LEN-1:0] frame;
    logic                 in_frame, timeout, frame_ok, resend, rsp_valid, err;

    ps2_line_sync u_sync (
        .clk         (clk),
        .clr         (clr),
        .ps2_clk_i   (ps2_clk_in),
        .ps2_data_i  (ps2_data_in),
        .data_sync_o (data_sync),
        .clk_fall_o  (clk_fall)
    );

    // Bits arrive LSB first, so the frame under evaluation has the current line bit on top.
    assign frame    = {data_sync, shift_q};
    assign frame_ok = ~frame[0] & (^frame[9:1]) & frame[FRAME_LEN-1];
    assign in_frame = state_q inside {ST_SEND, ST_LACK, ST_RSP};
    assign timeout  = in_frame && !clk_fall && (tmr_q == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q    <= ST_IDLE;
            cmd_q      <= '0;
            retry_q    <= '0;
            tmr_q      <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            data_oe_q  <= 1'b0;
            rsp_data_q <= '0;
        end else begin
            state_q    <= state_d;
            cmd_q      <= cmd_d;
            retry_q    <= retry_d;
            tmr_q      <= tmr_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            data_oe_q  <= data_oe_d;
            rsp_data_q <= rsp_data_d;
        end
    end

    // NOTE: every variable gets its default first, so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        cmd_d      = cmd_q;
        retry_d    = retry_q;
        tmr_d      = tmr_q;
        bit_d      = bit_q;
        shift_d    = shift_q;
        data_oe_d  = data_oe_q;
        rsp_data_d = rsp_data_q;
        rsp_valid  = 1'b0;
        err        = 1'b0;
        resend     = 1'b0;

        if (in_frame) tmr_d = clk_fall ? '0 : tmr_q + 1'b1;

        case (state_q)
            ST_IDLE: if (bus.cmd_valid) begin
                cmd_d   = bus.cmd_data;
                retry_d = '0;
                tmr_d   = '0;
                state_d = ST_INHIBIT;
            end
            // REQ is the last of the INHIBIT_CYCLES cycles with the clock held low.
            ST_INHIBIT: begin
                if (tmr_q == TW'(INHIBIT_CYCLES - 2)) state_d = ST_REQ;
                else                                  tmr_d   = tmr_q + 1'b1;
            end
            ST_REQ: begin
                tmr_d     = '0;
                bit_d     = '0;
                data_oe_d = 1'b1;
                state_d   = ST_SEND;
            end
            ST_SEND: if (clk_fall) begin
                bit_d = bit_q + 4'd1;
                if (bit_q < 4'd8)       data_oe_d = ~cmd_q[bit_q[2:0]];
                else if (bit_q == 4'd8) data_oe_d = ~odd_parity(cmd_q);
                else begin
                    data_oe_d = 1'b0;
                    bit_d     = '0;
                    state_d   = ST_LACK;
                end
            end
            ST_LACK: if (clk_fall) begin
                if (!data_sync) begin
                    bit_d   = '0;
                    state_d = ST_RSP;
                end else begin
                    resend = 1'b1;
                end
            end
            ST_RSP: if (clk_fall) begin
                shift_d = frame[FRAME_LEN-1:1];
                bit_d   = bit_q + 4'd1;
                if (bit_q == 4'(FRAME_LEN - 1)) begin
                    if (!frame_ok) begin
                        err     = 1'b1;
                        state_d = ST_IDLE;
                    end else if (frame[8:1] == PS2_RESEND) begin
                        resend = 1'b1;
                    end else begin
                        rsp_valid  = 1'b1;
                        rsp_data_d = frame[8:1];
                        state_d    = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (resend) begin
            if (retry_q < RW'(MAX_RETRIES)) begin
                retry_d = retry_q + 1'b1;
                tmr_d   = '0;
                state_d = ST_INHIBIT;
            end else begin
                err     = 1'b1;
                state_d = ST_IDLE;
            end
        end

        if (timeout) begin
            err     = 1'b1;
            state_d = ST_IDLE;
        end
    end

    assign ps2_clk_oe  = (state_q == ST_INHIBIT) || (state_q == ST_REQ);
    assign ps2_data_oe = (state_q == ST_REQ) || ((state_q == ST_SEND) && data_oe_q && !timeout);

    assign bus.cmd_ready  = (state_q == ST_IDLE);
    assign bus.busy       = (state_q != ST_IDLE);
    assign bus.rx_inhibit = (state_q != ST_IDLE);
    assign bus.rsp_valid  = rsp_valid;
    assign bus.err        = err;
    // The new byte is visible during the rsp_valid pulse and held afterwards.
    assign bus.rsp_data   = rsp_data_d;
endmodule

// File: tb/tb_ps2_host_ctl.sv
// tb_ps2_host_ctl: PS/2 device model plus response scoreboard for ps2_host_ctl.
module tb_ps2_host_ctl;
    localparam int CLK_PERIOD = 10;
    localparam int INH        = 2500;
    localparam int TMO        = 1000;
    localparam int RET        = 2;
    localparam int H          = 20;

    typedef struct {
        bit         is_err;
        logic [7:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic clr = 1'b1;
    logic dev_clk = 1'b1;
    logic dev_data = 1'b1;
    logic ps2_clk_oe, ps2_data_oe;
    wire  clk_line  = dev_clk & ~ps2_clk_oe;
    wire  data_line = dev_data & ~ps2_data_oe;

    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t sb[$];
    time  t_pulse, t_err, t_busy_fall, t_fall;
    logic [1:0] err_oe;
    logic busy_prev = 1'b0;
    logic last_parity;

    ps2_host_ctl_if bus ();

    ps2_host_ctl #(
        .INHIBIT_CYCLES (INH),
        .TIMEOUT_CYCLES (TMO),
        .MAX_RETRIES    (RET)
    ) dut (
        .clk         (clk),
        .clr         (clr),
        .bus         (bus),
        .ps2_clk_in  (clk_line),
        .ps2_data_in (data_line),
        .ps2_clk_oe  (ps2_clk_oe),
        .ps2_data_oe (ps2_data_oe)
    );

    always #(CLK_PERIOD / 2) clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic exp_t mk(input bit is_err, input logic [7:0] data);
        exp_t e;
        e.is_err = is_err;
        e.data   = data;
        return e;
    endfunction

    // Scoreboard consumer: every rsp_valid/err pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (!clr) begin
            if (bus.rsp_valid || bus.err) begin
                check("pulse_exclusive", bus.rsp_valid & bus.err, 0);
                if (sb.size() == 0) begin
                    check("pulse_expected", sb.size(), 1);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("pulse_kind_err", bus.err, e.is_err);
                    if (!e.is_err) check("rsp_data", bus.rsp_data, e.data);
                end
                t_pulse <= $time;
                if (bus.err) begin
                    t_err  <= $time;
                    err_oe <= {ps2_clk_oe, ps2_data_oe};
                end
            end
            if (busy_prev && !bus.busy) t_busy_fall <= $time;
            busy_prev <= bus.busy;
        end
    end

    task automatic host_send(input logic [7:0] b);
        int n;
        n = 0;
        while (!bus.cmd_ready && n < 20000) begin
            @(negedge clk);
            n++;
        end
        check("host_ready_seen", bus.cmd_ready, 1);
        bus.cmd_data  = b;
        bus.cmd_valid = 1'b1;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        check("busy_after_accept", {bus.busy, bus.rx_inhibit, bus.cmd_ready}, 3'b110);
    endtask

    // Device side of one exchange; stop_after>0 stops clocking after that falling edge.
    task automatic dev_txn(input logic [7:0] cmd, input logic [7:0] reply, input bit bad_par,
                           input int stop_after);
        int n;
        logic [10:0] got, exp_f, rsp_f;
        n = 0;
        while (clk_line !== 1'b0 && n < 20000) begin
            @(negedge clk);
            n++;
        end
        while (!(clk_line === 1'b1 && data_line === 1'b0) && n < 20000) begin
            @(negedge clk);
            n++;
        end
        check("dev_req_seen", n < 20000, 1);
        if (n >= 20000) return;
        got    = '0;
        got[0] = data_line;
        cyc(5);
        for (int e = 1; e <= 10; e++) begin
            dev_clk = 1'b0;
            t_fall  = $time;
            cyc(H);
            dev_clk = 1'b1;
            if (e == stop_after) return;
            cyc(H / 2);
            got[e] = data_line;
            cyc(H / 2);
        end
        exp_f = {1'b1, ~^cmd, cmd, 1'b0};
        check("tx_frame", got, exp_f);
        last_parity = got[9];
        dev_data = 1'b0;
        cyc(H / 2);
        dev_clk = 1'b0;
        cyc(H);
        dev_clk  = 1'b1;
        dev_data = 1'b1;
        cyc(H);
        rsp_f = {1'b1, (~^reply) ^ bad_par, reply, 1'b0};
        for (int i = 0; i < 11; i++) begin
            dev_data = rsp_f[i];
            cyc(H / 2);
            dev_clk = 1'b0;
            cyc(H);
            dev_clk = 1'b1;
            cyc(H / 2);
        end
        dev_data = 1'b1;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (bus.busy && n < 20000) begin
            @(negedge clk);
            n++;
        end
        check(tag, bus.busy, 0);
    endtask

    task automatic measure_req();
        int n, cnt, first;
        n = 0;
        while (!ps2_clk_oe && n < 10000) begin
            @(negedge clk);
            n++;
        end
        cnt   = 0;
        first = 0;
        while (ps2_clk_oe && cnt < 10000) begin
            cnt++;
            if (ps2_data_oe && first == 0) first = cnt;
            @(negedge clk);
        end
        check("inhibit_len", cnt, INH);
        check("data_lead_cycles", cnt - first + 1, 1);
        check("start_bit_held", ps2_data_oe, 1);
    endtask

    initial begin
        #(2_000_000);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_data  = 8'h00;
        cyc(3);
        check("rst_oe", {ps2_clk_oe, ps2_data_oe}, 2'b00);
        check("rst_ready_busy_inh", {bus.cmd_ready, bus.busy, bus.rx_inhibit}, 3'b100);
        check("rst_pulses", {bus.rsp_valid, bus.err}, 2'b00);
        check("rst_rsp_data", bus.rsp_data, 8'h00);
        clr = 1'b0;
        cyc(3);

        // F4 enable, FA reply; busy drops the cycle after the pulse.
        sb.push_back(mk(1'b0, 8'hFA));
        fork
            host_send(8'hF4);
            dev_txn(8'hF4, 8'hFA, 1'b0, 0);
        join
        wait_idle("idle_f4");
        check("busy_fall_after_rsp", 32'(t_busy_fall - t_pulse), CLK_PERIOD);
        check("sb_empty_f4", sb.size(), 0);

        // Request timing for 00; reply BAT_OK.
        sb.push_back(mk(1'b0, 8'hAA));
        fork
            host_send(8'h00);
            measure_req();
            dev_txn(8'h00, 8'hAA, 1'b0, 0);
        join
        wait_idle("idle_00");
        check("parity_00", last_parity, 1);
        check("sb_empty_00", sb.size(), 0);

        // ED: FE, FE then FA -> three transmissions and a single FA.
        sb.push_back(mk(1'b0, 8'hFA));
        fork
            host_send(8'hED);
            begin
                dev_txn(8'hED, 8'hFE, 1'b0, 0);
                dev_txn(8'hED, 8'hFE, 1'b0, 0);
                dev_txn(8'hED, 8'hFA, 1'b0, 0);
            end
        join
        wait_idle("idle_ed_retry");
        check("sb_empty_ed_retry", sb.size(), 0);

        // ED: FE three times -> retries exhausted.
        sb.push_back(mk(1'b1, 8'h00));
        fork
            host_send(8'hED);
            begin
                dev_txn(8'hED, 8'hFE, 1'b0, 0);
                dev_txn(8'hED, 8'hFE, 1'b0, 0);
                dev_txn(8'hED, 8'hFE, 1'b0, 0);
            end
        join
        wait_idle("idle_ed_exhaust");
        check("sb_empty_ed_exhaust", sb.size(), 0);

        // Device stops after edge 5; err comes TMO cycles after the edge is seen
        // (edge seen two clk edges after the line falls, observed on the next negedge).
        sb.push_back(mk(1'b1, 8'h00));
        fork
            host_send(8'h0F);
            dev_txn(8'h0F, 8'h00, 1'b0, 5);
        join
        wait_idle("idle_timeout");
        check("timeout_gap", 32'(t_err - t_fall), (TMO + 2) * CLK_PERIOD);
        check("timeout_lines_released", err_oe, 2'b00);
        check("timeout_ready", bus.cmd_ready, 1);
        check("sb_empty_timeout", sb.size(), 0);

        // Response FA with flipped parity -> err, no rsp_valid.
        sb.push_back(mk(1'b1, 8'h00));
        fork
            host_send(8'hF4);
            dev_txn(8'hF4, 8'hFA, 1'b1, 0);
        join
        wait_idle("idle_bad_par");
        check("sb_empty_bad_par", sb.size(), 0);

        // clr during SEND bit 3 releases both lines without a clock edge.
        fork
            host_send(8'h00);
            dev_txn(8'h00, 8'h00, 1'b0, 3);
        join
        check("pre_clr_data_oe", ps2_data_oe, 1);
        #2;
        clr = 1'b1;
        #1;
        check("clr_async_oe", {ps2_clk_oe, ps2_data_oe}, 2'b00);
        check("clr_async_status", {bus.cmd_ready, bus.busy, bus.rx_inhibit}, 3'b100);
        cyc(3);
        clr = 1'b0;
        cyc(3);
        sb.push_back(mk(1'b0, 8'hFA));
        fork
            host_send(8'hFF);
            dev_txn(8'hFF, 8'hFA, 1'b0, 0);
        join
        wait_idle("idle_after_clr");
        cyc(5);
        check("sb_drain", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
